// File: rtl/ov_reg_seq_if.sv
// Purpose : write-side connection between ov_reg_seq and the camera I2C
//           write controller (iic_ctrl).
// Signals : iic_data   - 24-bit {reg_addr, reg_data} for the controller's data_in
//           iic_enable - controller enable
//           iic_start  - controller start_xfer; high holds the controller idle
//                        and releases the bus
//           iic_done   - controller xfer_done
// Modports: master = sequencer side, slave = controller side.
`timescale 1ns/1ps

interface ov_reg_seq_if;
  logic [23:0] iic_data;
  logic        iic_enable;
  logic        iic_start;
  logic        iic_done;

  modport master (output iic_data, output iic_enable, output iic_start, input iic_done);
  modport slave  (input iic_data, input iic_enable, input iic_start, output iic_done);
endinterface

// File: rtl/ov_reg_seq.sv
// Purpose : register-init sequencer for an OV13850 bring-up table. After a go
//           request it waits for sensor power-up, then walks a synchronous init
//           ROM of {reg_addr[15:0], reg_data[7:0]} entries. Each entry becomes
//           one I2C write through iic_ctrl. 24'hFFFFFF ends the table, and
//           {16'hFFFE, ms} inserts a delay of ms milliseconds.
// Ports   : clock_in, reset_n (async assert, active low)
//           go        - level start request, honoured only in IDLE and DONE
//           rom_addr  - ROM read address; rom_data is valid one cycle later
//           rom_data  - ROM read data
//           iic       - ov_reg_seq_if.master toward the I2C controller
//           busy      - high in every state except IDLE and DONE
//           seq_done  - high in DONE
//           err       - sticky watchdog error
// Options : define OV_REG_SEQ_TIMEOUT_EN to build the WAIT_DONE watchdog.
//           Without it, err is tied low and WAIT_DONE waits indefinitely.
`timescale 1ns/1ps

module ov_reg_seq #(
  parameter int unsigned ADDR_W      = 9,
  parameter logic [31:0] PWR_DLY_CYC = 32'd50000,
  parameter logic [31:0] CLK_PER_MS  = 32'd25000,
  parameter int unsigned START_LEN   = 2,
  parameter int unsigned GAP_CYC     = 16,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic              go,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [23:0]       rom_data,
  ov_reg_seq_if.master      iic,
  output logic              busy,
  output logic              seq_done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}};
  localparam logic [31:0]       PWR_LAST   = PWR_DLY_CYC - 32'd1;
  localparam logic [31:0]       START_LAST = 32'(START_LEN - 1);
  localparam logic [31:0]       GAP_LAST   = 32'(GAP_CYC - 1);
  localparam logic [31:0]       DONE_IGN   = 32'd2;

  // Parameter sanity: the start hold, the bus gap and the watchdog window must be non-empty.
  if (START_LEN < 1) begin : g_bad_start_len
    $error("ov_reg_seq: START_LEN must be at least 1");
  end
  if (GAP_CYC < 1) begin : g_bad_gap_cyc
    $error("ov_reg_seq: GAP_CYC must be at least 1");
  end
  if (TIMEOUT_CYC <= 32'(DONE_IGN)) begin : g_bad_timeout_cyc
    $error("ov_reg_seq: TIMEOUT_CYC must exceed the xfer_done ignore window");
  end

`ifdef OV_REG_SEQ_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
`endif

  typedef enum logic [3:0] {
    IDLE, PWR_WAIT, FETCH, LATCH, START_HI, START_LO,
    WAIT_DONE, GAP, DELAY, NEXT, DONE
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [39:0] dly_cnt;

  // Entry decode, valid in LATCH
  logic [23:0] entry;
  logic        is_term;
  logic        is_delay;
  logic [39:0] dly_load;

  assign entry    = rom_data;
  assign is_term  = (entry == 24'hFFFFFF);
  assign is_delay = (entry[23:8] == 16'hFFFE);
  assign dly_load = 40'(entry[7:0]) * 40'(CLK_PER_MS);

`ifndef OV_REG_SEQ_TIMEOUT_EN
  assign err = 1'b0;
`endif

  // Sequencer FSM; every output is a register so reset releases the bus at once.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      rom_addr       <= '0;
      iic.iic_data   <= '0;
      iic.iic_enable <= 1'b0;
      iic.iic_start  <= 1'b1;
      busy           <= 1'b0;
      seq_done       <= 1'b0;
      cnt            <= '0;
      dly_cnt        <= '0;
`ifdef OV_REG_SEQ_TIMEOUT_EN
      err            <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            state    <= PWR_WAIT;
            cnt      <= '0;
            rom_addr <= '0;
            busy     <= 1'b1;
`ifdef OV_REG_SEQ_TIMEOUT_EN
            err      <= 1'b0;
`endif
          end
        end

        PWR_WAIT: begin
          if (cnt == PWR_LAST) begin
            state    <= FETCH;
            cnt      <= '0;
            rom_addr <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        // One cycle of synchronous ROM latency
        FETCH: state <= LATCH;

        LATCH: begin
          if (is_term) begin
            state          <= DONE;
            busy           <= 1'b0;
            seq_done       <= 1'b1;
            iic.iic_enable <= 1'b0;
          end else if (is_delay) begin
            if (entry[7:0] == 8'd0) begin
              state <= NEXT;
            end else begin
              state   <= DELAY;
              dly_cnt <= dly_load;
            end
          end else begin
            iic.iic_data   <= entry;
            iic.iic_enable <= 1'b1;
            cnt            <= '0;
            state          <= START_HI;
          end
        end

        START_HI: begin
          if (cnt == START_LAST) begin
            state         <= START_LO;
            iic.iic_start <= 1'b0;
            cnt           <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        START_LO: begin
          state <= WAIT_DONE;
          cnt   <= '0;
        end

        // xfer_done is not trusted until the controller has left its idle state
        WAIT_DONE: begin
          if (iic.iic_done && (cnt >= DONE_IGN)) begin
            iic.iic_start <= 1'b1;
            cnt           <= '0;
            state         <= GAP;
          end
`ifdef OV_REG_SEQ_TIMEOUT_EN
          else if (cnt == TIMEOUT_LAST) begin
            err            <= 1'b1;
            iic.iic_start  <= 1'b1;
            iic.iic_enable <= 1'b0;
            busy           <= 1'b0;
            seq_done       <= 1'b1;
            cnt            <= '0;
            state          <= DONE;
          end
`endif
          else if (cnt != 32'hFFFF_FFFF) begin
            cnt <= cnt + 32'd1;
          end
        end

        GAP: begin
          if (cnt == GAP_LAST) begin
            state <= NEXT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        DELAY: begin
          if (dly_cnt == 40'd0) begin
            state <= NEXT;
          end else begin
            dly_cnt <= dly_cnt - 40'd1;
          end
        end

        // Running off the end of the ROM is a normal finish, not an error
        NEXT: begin
          if (rom_addr == LAST_ADDR) begin
            state          <= DONE;
            busy           <= 1'b0;
            seq_done       <= 1'b1;
            iic.iic_enable <= 1'b0;
          end else begin
            rom_addr <= rom_addr + 1'b1;
            state    <= FETCH;
          end
        end

        DONE: begin
          iic.iic_enable <= 1'b0;
          if (go) begin
            state    <= PWR_WAIT;
            rom_addr <= '0;
            seq_done <= 1'b0;
            busy     <= 1'b1;
            cnt      <= '0;
`ifdef OV_REG_SEQ_TIMEOUT_EN
            err      <= 1'b0;
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ov_reg_seq.md
Name: ov_reg_seq

Overview:
- Register-init sequencer that sits directly upstream of the camera I2C write controller (`iic_ctrl`) and drives its data_in, enable and start_xfer inputs.
- Walks a synchronous init ROM of 24-bit entries, each {reg_addr[15:0], reg_data[7:0]}.
- Issues one I2C write per entry and waits for xfer_done before fetching the next entry.
- Supports timed-delay entries and a terminator entry, so a full OV13850 bring-up table runs unattended after a single go request.

Parameters:
- ADDR_W, 9, ROM address width; the table holds at most 2^ADDR_W entries.
- PWR_DLY_CYC, 32'd50000, clock_in cycles to wait after go before the first ROM fetch (sensor power-up).
- CLK_PER_MS, 32'd25000, clock_in cycles per millisecond, used by delay entries.
- START_LEN, 2, cycles iic_start is held high before release; minimum 1.
- GAP_CYC, 16, idle cycles between consecutive I2C writes (bus free time).
- TIMEOUT_CYC, 1024, watchdog limit in cycles per write; used only with the optional feature.

Ports:
- clock_in  in  1  same clock that feeds the I2C controller.
- reset_n  in  1  asynchronous, active-low reset.
- go  in  1  level; sampled in IDLE and DONE to start a sequence.
- rom_addr  out  ADDR_W  ROM read address.
- rom_data  in  24  ROM data, valid one cycle after rom_addr changes.
- iic_data  out  24  drives the I2C controller's data_in; stable for the whole transfer.
- iic_enable  out  1  drives the controller's enable.
- iic_start  out  1  drives the controller's start_xfer; high means the controller is held idle and the bus is released.
- iic_done  in  1  the controller's xfer_done.
- busy  out  1  high in every state except IDLE and DONE.
- seq_done  out  1  high in DONE.
- err  out  1  watchdog error flag; tied 0 when the optional feature is not compiled in.

Behaviour:
- Reset (async assert, sync release) forces:
  - state=IDLE, rom_addr=0, iic_data=0, iic_enable=0, iic_start=1
  - busy=0, seq_done=0, err=0, all counters=0
- Reset asserted mid-transfer releases the bus immediately, because iic_start=1 disables the controller's drivers.
- iic_start is 1 in every state except START_LO and WAIT_DONE. The controller counter is therefore held at 0 while idle, and xfer_done cannot glitch high between writes.
- States and transitions:
  - IDLE: if go=1, move to PWR_WAIT and clear the counter.
  - PWR_WAIT: count to PWR_DLY_CYC-1, then move to FETCH with rom_addr=0.
  - FETCH: one cycle for ROM latency, then LATCH.
  - LATCH: capture rom_data into entry, then decode:
    - entry==24'hFFFFFF (terminator): go to DONE.
    - entry[23:8]==16'hFFFE (delay entry): if entry[7:0]==0, go to NEXT; otherwise go to DELAY with count = entry[7:0]*CLK_PER_MS. The product uses a 40-bit counter and never overflows.
    - Any other entry: iic_data<=entry, iic_enable<=1, go to START_HI.
  - START_HI: hold iic_start=1 for START_LEN cycles, then START_LO.
  - START_LO: iic_start=0, then WAIT_DONE.
  - WAIT_DONE: iic_start=0 until iic_done=1. Then iic_start<=1 and go to GAP.
    - iic_done is ignored for the first 2 cycles of WAIT_DONE.
  - GAP: wait GAP_CYC cycles, then NEXT.
  - DELAY: count down to 0, then NEXT. iic_enable stays at its prior value.
  - NEXT: if rom_addr==2^ADDR_W-1, go to DONE (table exhausted with no terminator; not an error). Otherwise rom_addr+1 and go to FETCH.
  - DONE: seq_done=1, iic_enable=0. If go=1, restart at PWR_WAIT with rom_addr=0 and seq_done cleared.
- go is ignored while busy.
- Minimum cost per write entry: 1 FETCH + 1 LATCH + START_LEN + the controller transfer (~169 cycles) + GAP_CYC + 1 NEXT.
- A terminator at address 0 gives DONE with zero I2C writes and iic_enable never asserted.

Optional Feature:
- Macro: OV_REG_SEQ_TIMEOUT_EN.
- When defined:
  - A watchdog counts cycles spent in WAIT_DONE.
  - Reaching TIMEOUT_CYC sets err=1 (sticky until reset or the next go), forces iic_start=1 and iic_enable=0, and moves to DONE.
- When undefined:
  - No watchdog logic is built, err is tied 0, and WAIT_DONE waits indefinitely.

Test Plan:
- Table {0x3008_02, 0x0100_01, FFFFFF}, go pulse: after PWR_DLY_CYC, exactly two transfers occur. Each iic_data is stable while iic_start=0. seq_done=1 and rom_addr=2 at the end.
- Table {FFFE_03, 0x0100_01, FFFFFF} with CLK_PER_MS=10: iic_start first falls no earlier than 30 cycles after the delay entry is latched. FFFE_00 adds no delay.
- Reset asserted while iic_start=0 mid-transfer: same cycle gives iic_start=1 and iic_enable=0. After release: IDLE, busy=0, rom_addr=0.
- Table full of writes with no terminator, ADDR_W=2: exactly 4 writes, then DONE with rom_addr=3.
- With OV_REG_SEQ_TIMEOUT_EN and the iic_done model stuck at 0, TIMEOUT_CYC=64: err=1 after 64 WAIT_DONE cycles, then state DONE and iic_start=1. A second go clears err.
- go held high through DONE: the sequence restarts and PWR_WAIT is repeated. go pulses while busy have no effect.
